// File: rtl/multicycle_ctrl.sv
// Multi-cycle control FSM for an RV32 subset datapath (lw, sw, R, I-ALU, beq, jal).
// Ports: clk/rst_n, instruction fields, zero, mem_ready in; strobes, mux selects,
// ALUControl, illegal/mem_err pulses and debug state out.
module multicycle_ctrl #(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       MemWrite,
    output logic       AdrSrc,
    output logic       IRWrite,
    output logic       PCWrite,
    output logic       RegWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ImmSrc,
    output logic [2:0] ALUControl,
    output logic       illegal,
    output logic       mem_err,
    output logic [3:0] state
);

    localparam logic [3:0] S_FETCH    = 4'd0;
    localparam logic [3:0] S_DECODE   = 4'd1;
    localparam logic [3:0] S_MEMADR   = 4'd2;
    localparam logic [3:0] S_MEMREAD  = 4'd3;
    localparam logic [3:0] S_MEMWB    = 4'd4;
    localparam logic [3:0] S_MEMWRITE = 4'd5;
    localparam logic [3:0] S_EXECR    = 4'd6;
    localparam logic [3:0] S_ALUWB    = 4'd7;
    localparam logic [3:0] S_EXECI    = 4'd8;
    localparam logic [3:0] S_JAL      = 4'd9;
    localparam logic [3:0] S_BEQ      = 4'd10;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_BEQ = 7'b1100011;

    localparam logic [15:0] CNT_LAST =
        16'((MEM_TIMEOUT == 0) ? 0 : MEM_TIMEOUT - 1);

    logic [3:0]  state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [1:0]  alu_op;
    logic        in_mem, timeout;
    logic        req_c, mw_c, irw_c, pcw_c, rw_c, ill_c, err_c;

    assign in_mem = (state_q == S_FETCH) || (state_q == S_MEMREAD) ||
                    (state_q == S_MEMWRITE);

    // mem_ready on the last allowed cycle still completes normally
    assign timeout = in_mem && !mem_ready && (MEM_TIMEOUT != 0) &&
                     (cnt_q == CNT_LAST);

    always_comb begin
        state_d   = state_q;
        req_c     = 1'b0;
        mw_c      = 1'b0;
        irw_c     = 1'b0;
        pcw_c     = 1'b0;
        rw_c      = 1'b0;
        ill_c     = 1'b0;
        err_c     = 1'b0;
        AdrSrc    = 1'b0;
        ResultSrc = 2'b00;
        ALUSrcA   = 2'b00;
        ALUSrcB   = 2'b00;
        alu_op    = 2'b00;
        case (state_q)
            S_FETCH: begin
                req_c     = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                if (timeout) begin
                    err_c = 1'b1;
                end else if (mem_ready) begin
                    irw_c   = 1'b1;
                    pcw_c   = 1'b1;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
                case (opcode)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_R:         state_d = S_EXECR;
                    OP_I:         state_d = S_EXECI;
                    OP_JAL:       state_d = S_JAL;
                    OP_BEQ:       state_d = S_BEQ;
                    default: begin
                        ill_c   = 1'b1;
                        state_d = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                state_d = (opcode == OP_SW) ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                req_c  = 1'b1;
                AdrSrc = 1'b1;
                if (timeout) begin
                    err_c   = 1'b1;
                    state_d = S_FETCH;
                end else if (mem_ready) begin
                    state_d = S_MEMWB;
                end
            end
            S_MEMWB: begin
                ResultSrc = 2'b01;
                rw_c      = 1'b1;
                state_d   = S_FETCH;
            end
            S_MEMWRITE: begin
                req_c  = 1'b1;
                AdrSrc = 1'b1;
                mw_c   = !timeout;
                if (timeout) begin
                    err_c   = 1'b1;
                    state_d = S_FETCH;
                end else if (mem_ready) begin
                    state_d = S_FETCH;
                end
            end
            S_EXECR: begin
                ALUSrcA = 2'b10;
                alu_op  = 2'b10;
                state_d = S_ALUWB;
            end
            S_EXECI: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                alu_op  = 2'b10;
                state_d = S_ALUWB;
            end
            S_ALUWB: begin
                rw_c    = 1'b1;
                state_d = S_FETCH;
            end
            S_JAL: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b10;
                pcw_c   = 1'b1;
                state_d = S_ALUWB;
            end
            S_BEQ: begin
                ALUSrcA = 2'b10;
                alu_op  = 2'b01;
                pcw_c   = zero;
                state_d = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase
    end

    // counter restarts whenever the FSM moves or the access completes
    always_comb begin
        cnt_d = 16'd0;
        if (in_mem && !mem_ready && !timeout && (state_d == state_q))
            cnt_d = cnt_q + 16'd1;
    end

    always_comb begin
        ALUControl = 3'b000;
        case (alu_op)
            2'b01: ALUControl = 3'b010;
            2'b10: begin
                case (funct3)
                    3'b000:  ALUControl = (opcode[5] & funct7b5) ? 3'b010 : 3'b000;
                    3'b001:  ALUControl = 3'b001;
                    3'b100:  ALUControl = 3'b100;
                    3'b101:  ALUControl = 3'b101;
                    3'b110:  ALUControl = 3'b110;
                    3'b111:  ALUControl = 3'b111;
                    default: ALUControl = 3'b000;
                endcase
            end
            default: ALUControl = 3'b000;
        endcase
    end

    always_comb begin
        case (opcode)
            OP_SW:   ImmSrc = 2'b01;
            OP_BEQ:  ImmSrc = 2'b10;
            OP_JAL:  ImmSrc = 2'b11;
            default: ImmSrc = 2'b00;
        endcase
    end

    // strobes are forced low for as long as reset is held
    assign mem_req  = rst_n & req_c;
    assign MemWrite = rst_n & mw_c;
    assign IRWrite  = rst_n & irw_c;
    assign PCWrite  = rst_n & pcw_c;
    assign RegWrite = rst_n & rw_c;
    assign illegal  = rst_n & ill_c;
    assign mem_err  = rst_n & err_c;
    assign state    = state_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
            cnt_q   <= 16'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: per-instruction expected cycle lists built from
// the instruction semantics, replayed against the DUT and compared every cycle.
module tb_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       zero;
    logic       mem_ready;
    logic       mem_req, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
    logic [2:0] ALUControl;
    logic       illegal, mem_err;
    logic [3:0] state;

    int tests = 0;
    int fails = 0;

    multicycle_ctrl #(.MEM_TIMEOUT(16)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct3(funct3),
        .funct7b5(funct7b5), .zero(zero), .mem_ready(mem_ready),
        .mem_req(mem_req), .MemWrite(MemWrite), .AdrSrc(AdrSrc),
        .IRWrite(IRWrite), .PCWrite(PCWrite), .RegWrite(RegWrite),
        .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ImmSrc(ImmSrc), .ALUControl(ALUControl), .illegal(illegal),
        .mem_err(mem_err), .state(state)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] st;
        logic       req, mw, adr, irw, pcw, rw;
        logic [1:0] rs, sa, sb;
        logic [2:0] alu;
        logic       ill, err, rdy;
    } cyc_t;

    cyc_t q[$];
    cyc_t exp_c;
    bit   exp_valid = 0;

    localparam logic [6:0] LW  = 7'b0000011;
    localparam logic [6:0] SW  = 7'b0100011;
    localparam logic [6:0] RT  = 7'b0110011;
    localparam logic [6:0] IT  = 7'b0010011;
    localparam logic [6:0] JL  = 7'b1101111;
    localparam logic [6:0] BQ  = 7'b1100011;

    function automatic bit legal(input logic [6:0] op);
        return op == LW || op == SW || op == RT || op == IT || op == JL || op == BQ;
    endfunction

    function automatic logic [1:0] imm_of(input logic [6:0] op);
        if (op == SW) return 2'b01;
        if (op == BQ) return 2'b10;
        if (op == JL) return 2'b11;
        return 2'b00;
    endfunction

    // ALU operation an R/I-type instruction asks for
    function automatic logic [2:0] op_alu(input logic [6:0] op, input logic [2:0] f3,
                                          input logic f7);
        case (f3)
            3'b000:  return (op == RT && f7) ? 3'b010 : 3'b000;
            3'b001:  return 3'b001;
            3'b100:  return 3'b100;
            3'b101:  return 3'b101;
            3'b110:  return 3'b110;
            3'b111:  return 3'b111;
            default: return 3'b000;
        endcase
    endfunction

    function automatic cyc_t blank(input logic [3:0] st);
        cyc_t c;
        c.st = st; c.req = 0; c.mw = 0; c.adr = 0; c.irw = 0; c.pcw = 0;
        c.rw = 0; c.rs = 0; c.sa = 0; c.sb = 0; c.alu = 0; c.ill = 0;
        c.err = 0; c.rdy = 1'($urandom_range(0, 1));
        return c;
    endfunction

    // n waiting cycles; 16 or more means the access times out
    task automatic mem_phase(input logic [3:0] st, input int n, output bit to);
        cyc_t c;
        c = blank(st);
        c.req = 1;
        if (st == 4'd0) begin c.sb = 2; c.rs = 2; end
        else c.adr = 1;
        if (st == 4'd5) c.mw = 1;
        for (int i = 0; i < ((n >= 16) ? 15 : n); i++) begin
            c.rdy = 0; q.push_back(c);
        end
        if (n >= 16) begin
            c.rdy = 0; c.err = 1; c.mw = 0; q.push_back(c); to = 1;
        end else begin
            c.rdy = 1;
            if (st == 4'd0) begin c.irw = 1; c.pcw = 1; end
            q.push_back(c); to = 0;
        end
    endtask

    task automatic build(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                         input logic z, input int nf, input int nm);
        cyc_t c;
        bit to;
        q.delete();
        mem_phase(4'd0, nf, to);
        if (to) return;
        c = blank(4'd1); c.sa = 1; c.sb = 1; c.ill = !legal(op);
        q.push_back(c);
        if (c.ill) return;
        if (op == LW || op == SW) begin
            c = blank(4'd2); c.sa = 2; c.sb = 1; q.push_back(c);
            if (op == LW) begin
                mem_phase(4'd3, nm, to);
                if (to) return;
                c = blank(4'd4); c.rs = 1; c.rw = 1; q.push_back(c);
            end else begin
                mem_phase(4'd5, nm, to);
            end
        end else if (op == RT || op == IT) begin
            c = blank(op == RT ? 4'd6 : 4'd8);
            c.sa = 2; c.sb = (op == RT) ? 2'd0 : 2'd1; c.alu = op_alu(op, f3, f7);
            q.push_back(c);
            c = blank(4'd7); c.rw = 1; q.push_back(c);
        end else if (op == JL) begin
            c = blank(4'd9); c.sa = 1; c.sb = 2; c.pcw = 1; q.push_back(c);
            c = blank(4'd7); c.rw = 1; q.push_back(c);
        end else begin
            c = blank(4'd10); c.sa = 2; c.alu = 3'b010; c.pcw = z; q.push_back(c);
        end
    endtask

    task automatic set_instr(input logic [6:0] op, input logic [2:0] f3,
                             input logic f7, input logic z);
        opcode = op; funct3 = f3; funct7b5 = f7; zero = z;
    endtask

    // entered just after a rising edge
    task automatic play();
        foreach (q[i]) begin
            rst_n = 1'b1;
            mem_ready = q[i].rdy;
            exp_c = q[i];
            exp_valid = 1;
            @(posedge clk); #1;
        end
    endtask

    task automatic run(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                       input logic z, input int nf, input int nm);
        set_instr(op, f3, f7, z);
        build(op, f3, f7, z, nf, nm);
        play();
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h want %0h", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (exp_valid) begin
            logic [22:0] a, e;
            a = {mem_req, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite,
                 ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUControl,
                 illegal, mem_err, state};
            e = {exp_c.req, exp_c.mw, exp_c.adr, exp_c.irw, exp_c.pcw, exp_c.rw,
                 exp_c.rs, exp_c.sa, exp_c.sb, imm_of(opcode), exp_c.alu,
                 exp_c.ill, exp_c.err, exp_c.st};
            tests++;
            if (a !== e) begin
                fails++;
                $display("FAIL cycle t=%0t op=%b state=%0d: got %h want %h",
                         $time, opcode, state, a, e);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 0; mem_ready = 0;
        set_instr(RT, 3'b000, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        chk("reset_state", {28'd0, state}, 32'd0);
        chk("reset_strobes", {mem_req, MemWrite, IRWrite, PCWrite, RegWrite, illegal, mem_err}, 0);

        // add x3,x1,x2
        set_instr(RT, 3'b000, 1'b0, 1'b0);
        build(RT, 3'b000, 1'b0, 1'b0, 0, 0);
        chk("pin_add_len", q.size(), 4);
        chk("pin_add_states", {q[0].st, q[1].st, q[2].st, q[3].st}, 16'h0167);
        chk("pin_add_alu", q[2].alu, 3'b000);
        chk("pin_add_rw", {q[0].rw, q[1].rw, q[2].rw, q[3].rw}, 4'b0001);
        play();

        build(RT, 3'b000, 1'b1, 1'b0, 0, 0);
        chk("pin_sub_alu", q[2].alu, 3'b010);
        run(RT, 3'b000, 1'b1, 1'b0, 0, 0);
        build(IT, 3'b000, 1'b1, 1'b0, 0, 0);
        chk("pin_addi_alu", q[2].alu, 3'b000);
        run(IT, 3'b000, 1'b1, 1'b0, 0, 0);
        run(IT, 3'b101, 1'b0, 1'b0, 0, 0);

        build(LW, 3'b010, 1'b0, 1'b0, 0, 0);
        chk("pin_lw_len", q.size(), 5);
        build(SW, 3'b010, 1'b0, 1'b0, 0, 0);
        chk("pin_sw_len", q.size(), 4);
        build(JL, 3'b000, 1'b0, 1'b0, 0, 0);
        chk("pin_jal_len", q.size(), 4);
        build(BQ, 3'b000, 1'b0, 1'b1, 0, 0);
        chk("pin_beq_len", q.size(), 3);
        chk("pin_beq_pcw", q[2].pcw, 1'b1);

        run(LW, 3'b010, 1'b0, 1'b0, 0, 3);
        run(BQ, 3'b000, 1'b0, 1'b1, 0, 0);
        run(BQ, 3'b000, 1'b0, 1'b0, 0, 0);
        run(7'h7F, 3'b000, 1'b0, 1'b0, 0, 0);

        build(RT, 3'b000, 1'b0, 1'b0, 16, 0);
        chk("pin_timeout_len", q.size(), 16);
        chk("pin_timeout_err", q[15].err, 1'b1);
        run(RT, 3'b000, 1'b0, 1'b0, 16, 0);
        run(RT, 3'b110, 1'b0, 1'b0, 15, 0);
        run(LW, 3'b010, 1'b0, 1'b0, 0, 16);
        run(SW, 3'b010, 1'b0, 1'b0, 2, 16);
        run(SW, 3'b010, 1'b0, 1'b0, 0, 15);

        // reset while a store is waiting for memory
        exp_valid = 0;
        set_instr(SW, 3'b010, 1'b0, 1'b0);
        mem_ready = 1;
        @(posedge clk); #1;
        mem_ready = 0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("sw_in_memwrite", {28'd0, state}, 5);
        chk("sw_memwrite_hi", MemWrite, 1'b1);
        @(posedge clk); #1;
        rst_n = 0;
        #1;
        chk("rst_memwrite_lo", MemWrite, 1'b0);
        chk("rst_memreq_lo", mem_req, 1'b0);
        @(posedge clk); #1;
        chk("rst_state_fetch", {28'd0, state}, 0);
        chk("rst_memwrite_lo2", MemWrite, 1'b0);
        @(posedge clk); #1;
        run(LW, 3'b010, 1'b0, 1'b0, 15, 1);

        for (int n = 0; n < 70; n++) begin
            logic [6:0] op;
            int k, nf, nm;
            k = $urandom_range(0, 6);
            case (k)
                0: op = LW; 1: op = SW; 2: op = RT; 3: op = IT;
                4: op = JL; 5: op = BQ;
                default: begin
                    op = 7'($urandom_range(0, 127));
                    while (legal(op)) op = 7'($urandom_range(0, 127));
                end
            endcase
            nf = ($urandom_range(0, 9) == 0) ? $urandom_range(15, 16) : $urandom_range(0, 3);
            nm = ($urandom_range(0, 9) == 0) ? $urandom_range(15, 16) : $urandom_range(0, 4);
            run(op, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), nf, nm);
        end
        exp_valid = 0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
